// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundles the fetch port, the load/store data port and
// the shared memory-controller bus that mem_port_arbiter sits between.
//   slave  : view taken by the arbiter (takes requests and mem_rdata, drives
//            acks, read results, memory strobes/fields and busy)
//   master : view taken by the surrounding core/controller (the reverse)
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic        if_rvalid;
  logic [31:0] if_rdata;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [2:0]  d_size;
  logic        d_ack;
  logic        d_rvalid;
  logic [31:0] d_rdata;

  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  mem_u_b_h_w;
  logic [31:0] mem_rdata;

  logic        busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_size, mem_rdata,
    output if_ack, if_rvalid, if_rdata, d_ack, d_rvalid, d_rdata,
           mem_addr, mem_wdata, mem_read, mem_write, mem_u_b_h_w, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_size, mem_rdata,
    input  if_ack, if_rvalid, if_rdata, d_ack, d_rvalid, d_rdata,
           mem_addr, mem_wdata, mem_read, mem_write, mem_u_b_h_w, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one CPU memory interface between the instruction
// fetch port and the load/store data port, one transaction at a time.
// Grant in IDLE -> one-cycle strobe in ISSUE -> optional WAIT for RD_LAT
// cycles, then the read word is captured and a registered rvalid pulses.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : mem_port_arbiter_if.slave (fetch, data and memory-side signals)
// Parameter:
//   RD_LAT : cycles after the strobe cycle at which mem_rdata is sampled (0..7)
// Build option:
//   ARB_ROUND_ROBIN_EN : defined -> ties go to the master not granted last;
//                        undefined -> fixed priority, data beats fetch.
module mem_port_arbiter #(
  parameter int unsigned RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_port_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_t;

  state_t      state, state_nx;
  logic        grant_if, grant_d, capture;

  logic        owner_d;
  logic        t_we;
  logic [31:0] t_addr;
  logic [31:0] t_wdata;
  logic [2:0]  t_size;
  logic [2:0]  wait_cnt;

  logic        if_rvalid_q, d_rvalid_q;
  logic [31:0] if_rdata_q, d_rdata_q;

`ifdef ARB_ROUND_ROBIN_EN
  logic        last_d;   // 1: data was granted last
`endif

  always_comb begin
    grant_if = 1'b0;
    grant_d  = 1'b0;
    capture  = 1'b0;
    state_nx = state;
    unique case (state)
      S_IDLE: begin
`ifdef ARB_ROUND_ROBIN_EN
        grant_d  = bus.d_req && (!bus.if_req || !last_d);
`else
        grant_d  = bus.d_req;
`endif
        grant_if = bus.if_req && !grant_d;
        if (grant_d || grant_if) state_nx = S_ISSUE;
      end
      S_ISSUE: begin
        if (t_we) begin
          state_nx = S_IDLE;
        end else if (RD_LAT == 0) begin
          capture  = 1'b1;
          state_nx = S_IDLE;
        end else begin
          state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wait_cnt == 3'd1) begin
          capture  = 1'b1;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_d     <= 1'b0;
      t_we        <= 1'b0;
      t_addr      <= '0;
      t_wdata     <= '0;
      t_size      <= '0;
      wait_cnt    <= '0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      if (grant_d || grant_if) begin
        owner_d <= grant_d;
        t_we    <= grant_d && bus.d_we;
        t_addr  <= grant_d ? bus.d_addr  : bus.if_addr;
        t_wdata <= grant_d ? bus.d_wdata : '0;
        t_size  <= grant_d ? bus.d_size  : 3'b010;
      end
      if (state == S_ISSUE)     wait_cnt <= 3'(RD_LAT);
      else if (state == S_WAIT) wait_cnt <= wait_cnt - 3'd1;

      if_rvalid_q <= capture && !owner_d;
      d_rvalid_q  <= capture && owner_d;
      if (capture && !owner_d) if_rdata_q <= bus.mem_rdata;
      if (capture && owner_d)  d_rdata_q  <= bus.mem_rdata;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    last_d <= 1'b1;
    else if (grant_d || grant_if)  last_d <= grant_d;
  end
`endif

  assign bus.if_ack      = grant_if;
  assign bus.d_ack       = grant_d;
  assign bus.if_rvalid   = if_rvalid_q;
  assign bus.d_rvalid    = d_rvalid_q;
  assign bus.if_rdata    = if_rdata_q;
  assign bus.d_rdata     = d_rdata_q;
  assign bus.mem_addr    = t_addr;
  assign bus.mem_wdata   = t_wdata;
  assign bus.mem_u_b_h_w = t_size;
  assign bus.mem_read    = (state == S_ISSUE) && !t_we;
  assign bus.mem_write   = (state == S_ISSUE) && t_we;
  assign bus.busy        = (state != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized requests on both ports, checked
// each cycle against a transaction-level model (one outstanding transaction,
// timing derived from grant cycle + RD_LAT). The controller side returns the
// expected word only in the sampling cycle and random junk otherwise.
module tb_mem_port_arbiter;
  localparam int unsigned RD_LAT = 1;
  localparam int          RL     = RD_LAT;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.RD_LAT(RD_LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int ntest = 0;
  int nfail = 0;
  int n = 0;

  // model: the single outstanding transaction
  bit          pend;
  int          issue_cyc, rv_cyc, free_cyc;
  bit          p_data, p_we;
  logic [31:0] p_addr, p_wdata, p_rdata;
  logic [2:0]  p_size;
  // model: what the memory-side fields and result registers currently hold
  logic [31:0] cur_addr, cur_wdata;
  logic [2:0]  cur_size;
  bit          cur_wd_known;
  logic [31:0] m_if_rdata, m_d_rdata;
  bit          last_was_data;

  bit          force_en;
  logic [31:0] force_val;
  bit          got_f_ack, got_d_ack;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntest++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pend          = 1'b0;
    cur_addr      = '0;
    cur_wdata     = '0;
    cur_size      = '0;
    cur_wd_known  = 1'b1;
    m_if_rdata    = '0;
    m_d_rdata     = '0;
    last_was_data = 1'b1;
  endtask

  task automatic zero_inputs();
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.d_addr    = '0;
    bus.d_wdata   = '0;
    bus.d_size    = '0;
    bus.mem_rdata = '0;
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_if_ack"},    32'(bus.if_ack),      '0);
    chk({pfx, "_d_ack"},     32'(bus.d_ack),       '0);
    chk({pfx, "_if_rvalid"}, 32'(bus.if_rvalid),   '0);
    chk({pfx, "_d_rvalid"},  32'(bus.d_rvalid),    '0);
    chk({pfx, "_if_rdata"},  bus.if_rdata,         '0);
    chk({pfx, "_d_rdata"},   bus.d_rdata,          '0);
    chk({pfx, "_mem_addr"},  bus.mem_addr,         '0);
    chk({pfx, "_mem_wdata"}, bus.mem_wdata,        '0);
    chk({pfx, "_mem_read"},  32'(bus.mem_read),    '0);
    chk({pfx, "_mem_write"}, 32'(bus.mem_write),   '0);
    chk({pfx, "_size"},      32'(bus.mem_u_b_h_w), '0);
    chk({pfx, "_busy"},      32'(bus.busy),        '0);
  endtask

  // One clock cycle: drive requests, predict, compare, then commit any grant.
  task automatic step(input bit fr, input logic [31:0] fa, input bit dr, input bit dwe,
                      input logic [31:0] da, input logic [31:0] dwd, input logic [2:0] ds);
    bit e_rd, e_wr, e_frv, e_drv, e_busy, wd, wf;
    @(posedge clk);
    n++;
    #1;
    bus.if_req  = fr;
    bus.if_addr = fa;
    bus.d_req   = dr;
    bus.d_we    = dwe;
    bus.d_addr  = da;
    bus.d_wdata = dwd;
    bus.d_size  = ds;
    if (pend && n == issue_cyc) begin
      cur_addr     = p_addr;
      cur_size     = p_size;
      cur_wdata    = p_wdata;
      cur_wd_known = p_data;
    end
    if (pend && !p_we && n == issue_cyc + RL) bus.mem_rdata = p_rdata;
    else                                      bus.mem_rdata = $urandom;
    e_rd   = pend && n == issue_cyc && !p_we;
    e_wr   = pend && n == issue_cyc && p_we;
    e_frv  = pend && !p_we && !p_data && n == rv_cyc;
    e_drv  = pend && !p_we && p_data && n == rv_cyc;
    e_busy = pend && n < free_cyc;
    if (e_frv) m_if_rdata = p_rdata;
    if (e_drv) m_d_rdata  = p_rdata;
    wd = 1'b0;
    wf = 1'b0;
    if (!e_busy && (fr || dr)) begin
`ifdef ARB_ROUND_ROBIN_EN
      if (fr && dr) wd = !last_was_data;
      else          wd = dr;
`else
      wd = dr;
`endif
      wf = !wd;
    end
    #3;
    chk("if_ack",    32'(bus.if_ack),      32'(wf));
    chk("d_ack",     32'(bus.d_ack),       32'(wd));
    chk("mem_read",  32'(bus.mem_read),    32'(e_rd));
    chk("mem_write", 32'(bus.mem_write),   32'(e_wr));
    chk("busy",      32'(bus.busy),        32'(e_busy));
    chk("if_rvalid", 32'(bus.if_rvalid),   32'(e_frv));
    chk("d_rvalid",  32'(bus.d_rvalid),    32'(e_drv));
    chk("if_rdata",  bus.if_rdata,         m_if_rdata);
    chk("d_rdata",   bus.d_rdata,          m_d_rdata);
    chk("mem_addr",  bus.mem_addr,         cur_addr);
    chk("mem_size",  32'(bus.mem_u_b_h_w), 32'(cur_size));
    if (cur_wd_known) chk("mem_wdata", bus.mem_wdata, cur_wdata);
    got_f_ack = wf;
    got_d_ack = wd;
    if (wf || wd) begin
      pend          = 1'b1;
      issue_cyc     = n + 1;
      p_data        = wd;
      p_we          = wd && dwe;
      p_addr        = wd ? da  : fa;
      p_wdata       = wd ? dwd : '0;
      p_size        = wd ? ds  : 3'b010;
      p_rdata       = force_en ? force_val : 32'($urandom);
      rv_cyc        = n + RL + 2;
      free_cyc      = p_we ? n + 2 : rv_cyc;
      last_was_data = wd;
    end
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  // Requesters raise with given percentage, hold fields until ack, may drop early.
  task automatic run(input int cycles, input int f_pct, input int d_pct, input bit allow_drop);
    bit fh = 1'b0, dh = 1'b0, dwe = 1'b0;
    logic [31:0] fa = '0, da = '0, dwd = '0;
    logic [2:0]  ds = '0;
    for (int i = 0; i < cycles; i++) begin
      if (!fh && $urandom_range(99) < f_pct) begin
        fh = 1'b1;
        fa = $urandom;
      end else if (fh && allow_drop && $urandom_range(15) == 0) begin
        fh = 1'b0;
      end
      if (!dh && $urandom_range(99) < d_pct) begin
        dh  = 1'b1;
        dwe = 1'($urandom_range(1));
        da  = $urandom;
        dwd = $urandom;
        ds  = 3'($urandom_range(7));
      end else if (dh && allow_drop && $urandom_range(15) == 0) begin
        dh = 1'b0;
      end
      step(fh, fa, dh, dwe, da, dwd, ds);
      if (got_f_ack) fh = 1'b0;
      if (got_d_ack) dh = 1'b0;
    end
  endtask

  task automatic reset_mid();
    @(posedge clk);
    n++;
    #1;
    rst_n = 1'b0;
    zero_inputs();
    #3;
    chk_all_zero("midrst");
    model_reset();
    @(posedge clk);
    n++;
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    zero_inputs();
    force_en = 1'b0;
    force_val = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #3;
    chk_all_zero("reset");

    // fetch alone, controller returns 0x1234_5678
    force_en = 1'b1;
    force_val = 32'h1234_5678;
    step(1'b1, 32'h0000_0010, 1'b0, 1'b0, '0, '0, '0);
    idle(RL + 3);
    chk("fetch_word", bus.if_rdata, 32'h1234_5678);

    // byte store
    step(1'b0, '0, 1'b1, 1'b1, 32'h1000_0003, 32'h0000_00AB, 3'b000);
    idle(3);

    // data load of 0xDEAD_BEEF
    force_val = 32'hDEAD_BEEF;
    step(1'b0, '0, 1'b1, 1'b0, 32'h2000_0040, '0, 3'b010);
    idle(RL + 3);
    chk("load_word", bus.d_rdata, 32'hDEAD_BEEF);
    force_en = 1'b0;

    // both masters requesting continuously: arbitration order and back-to-back
    run(60, 100, 100, 1'b0);
    idle(RL + 3);

    // reset during an outstanding fetch, then a fresh fetch
    step(1'b1, 32'h0000_0080, 1'b0, 1'b0, '0, '0, '0);
    if (RL > 0) idle(1);
    reset_mid();
    idle(RL + 3);
    step(1'b1, 32'h0000_0084, 1'b0, 1'b0, '0, '0, '0);
    idle(RL + 3);

    // randomized traffic with early drops
    run(300, 40, 40, 1'b1);
    run(200, 80, 80, 1'b1);
    idle(RL + 3);

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
